// File: rtl/axi_arb_pkg.sv
// Shared definitions for the round-robin AXI read arbiter.
//   arb_state_e     : arbiter FSM states (ST_ERR only reachable when the
//                     AXI_ARB_TIMEOUT_EN macro is defined)
//   RESP_OKAY       : AXI OKAY response code
//   RESP_SLVERR     : AXI SLVERR response code
//   TIMEOUT_DEFAULT : default watchdog limit in cycles
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker.
//   req     : per-requester request vector
//   last    : index granted most recently; search starts at last+1
//   gnt_idx : first requesting index found, wrapping modulo NUM_M
//   any_req : high when at least one request is present
module axi_rr_pick #(
    parameter int unsigned NUM_M = 4
) (
    input  logic [NUM_M-1:0]         req,
    input  logic [$clog2(NUM_M)-1:0] last,
    output logic [$clog2(NUM_M)-1:0] gnt_idx,
    output logic                     any_req
);

    localparam int unsigned LW = $clog2(NUM_M);

    int unsigned   idx;
    logic [LW-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        idx     = 0;
        cand    = '0;
        // k runs 1..NUM_M so the last-granted requester is considered last.
        for (int unsigned k = 1; k <= NUM_M; k++) begin
            idx  = (32'(last) + k) % NUM_M;
            cand = LW'(idx);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/axi_rr_read_arbiter.sv
// Round-robin arbiter sharing one AXI read slave port between NUM_M
// requesters. Single-beat transfers, one outstanding transaction.
//   clk, rst                      : clock, synchronous active-low reset
//   m_arvalid/m_araddr/m_arready  : per-requester read-address channels
//   m_rvalid/m_rready/m_rresp/m_rdata : per-requester read-data channels
//   s_arvalid/s_araddr/s_arready  : shared slave read-address channel
//   s_rvalid/s_rready/s_rresp/s_rdata : shared slave read-data channel
// Compile-time option: define AXI_ARB_TIMEOUT_EN to add a watchdog that
// answers SLVERR to the granted requester after TIMEOUT cycles in ADDR/DATA.
module axi_rr_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM_M   = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 64,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_M-1:0]    m_arvalid,
    input  logic [NUM_M*AW-1:0] m_araddr,
    output logic [NUM_M-1:0]    m_arready,
    output logic [NUM_M-1:0]    m_rvalid,
    input  logic [NUM_M-1:0]    m_rready,
    output logic [NUM_M*2-1:0]  m_rresp,
    output logic [NUM_M*DW-1:0] m_rdata,
    output logic                s_arvalid,
    output logic [AW-1:0]       s_araddr,
    output logic                s_rready,
    input  logic                s_arready,
    input  logic                s_rvalid,
    input  logic [1:0]          s_rresp,
    input  logic [DW-1:0]       s_rdata
);

    localparam int unsigned LW = $clog2(NUM_M);

    arb_state_e    state, state_nxt;
    logic [LW-1:0] grant, last_grant, pick_idx;
    logic          any_req;
    logic          done;

    axi_rr_pick #(.NUM_M(NUM_M)) u_pick (
        .req     (m_arvalid),
        .last    (last_grant),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= LW'(NUM_M - 1);
            grant      <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) grant <= pick_idx;
            if (done) last_grant <= grant;
        end
    end

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] age;
    logic          expired;

    // Held at zero while idle, so every entry into ADDR starts from zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            age <= '0;
        end else if (state == ST_IDLE) begin
            age <= '0;
        end else if (state == ST_ADDR || state == ST_DATA) begin
            age <= age + 1'b1;
        end
    end

    // The counter reaches TIMEOUT on the same edge that moves into ERR.
    assign expired = (age == CW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rresp   = '0;
        m_rdata   = '0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_rready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                s_arvalid        = m_arvalid[grant];
                s_araddr         = m_araddr[grant*AW +: AW];
                m_arready[grant] = s_arready;
                if (m_arvalid[grant] && s_arready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                s_rready                = m_rready[grant];
                m_rvalid[grant]         = s_rvalid;
                m_rresp[grant*2 +: 2]   = s_rresp;
                m_rdata[grant*DW +: DW] = s_rdata;
                if (s_rvalid && m_rready[grant]) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end
            end
`ifdef AXI_ARB_TIMEOUT_EN
            ST_ERR: begin
                // Slave stays drained so a late beat is swallowed here.
                s_rready              = 1'b1;
                m_rvalid[grant]       = 1'b1;
                m_rresp[grant*2 +: 2] = RESP_SLVERR;
                if (m_rready[grant]) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
`ifdef AXI_ARB_TIMEOUT_EN
        if ((state == ST_ADDR || state == ST_DATA) && !done && expired) begin
            state_nxt = ST_ERR;
        end
`endif
    end

endmodule

// File: tb/tb_axi_rr_read_arbiter.sv
// Self-checking bench for axi_rr_read_arbiter (NUM_M=4, AW=32, DW=64).
// A transaction-level model predicts every DUT output each cycle; directed
// sequences pin the model with literal expectations. With
// AXI_ARB_TIMEOUT_EN defined the DUT is built with TIMEOUT=16 and the
// watchdog sequence is added.
module tb_axi_rr_read_arbiter;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 64;
`ifdef AXI_ARB_TIMEOUT_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 255;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NM-1:0]   m_arvalid, m_arready, m_rvalid, m_rready;
    logic [NM*AW-1:0] m_araddr;
    logic [NM*2-1:0] m_rresp;
    logic [NM*DW-1:0] m_rdata;
    logic            s_arvalid, s_rready, s_arready, s_rvalid;
    logic [AW-1:0]   s_araddr;
    logic [1:0]      s_rresp;
    logic [DW-1:0]   s_rdata;

    always #5 clk = ~clk;

    axi_rr_read_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW), .TIMEOUT(TB_TO)) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rresp(m_rresp), .m_rdata(m_rdata),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_rready(s_rready),
        .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rdata(s_rdata)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] slv_data(input logic [31:0] a);
        return {a, a} ^ 64'h9122_3344_D566_7788;
    endfunction

    function automatic int rr_pick(input logic [NM-1:0] req, input int last);
        for (int k = 1; k <= NM; k++) begin
            if (req[(last + k) % NM]) return (last + k) % NM;
        end
        return -1;
    endfunction

    // Slave model state and knobs
    bit          sl_busy = 0;
    int          sl_delay = 0;
    logic [31:0] sl_addr = '0;
    logic [1:0]  sl_resp = '0;
    int unsigned ar_pct = 100;
    int unsigned max_delay = 0;
    bit          resp_rand = 0;
    bit          sl_silent = 0;

    // Transaction model: who owns the port and how far its transfer got
    int          md_owner = -1;
    int          md_last = NM - 1;
    bit          md_addr_done = 0;
    bit          md_err = 0;
    int          md_age = 0;
    logic [31:0] md_addr = '0;

    int gnt_log[$];

    logic            e_s_arvalid, e_s_rready;
    logic [AW-1:0]   e_s_araddr;
    logic [NM-1:0]   e_m_arready, e_m_rvalid;
    logic [NM*2-1:0] e_m_rresp;
    logic [NM*DW-1:0] e_m_rdata;

    initial begin
        int o, gi, p;
        forever begin
            @(negedge clk);
            e_s_arvalid = 0; e_s_rready = 0; e_s_araddr = '0;
            e_m_arready = '0; e_m_rvalid = '0; e_m_rresp = '0; e_m_rdata = '0;
            o = md_owner;
            if (o >= 0) begin
                if (md_err) begin
                    e_s_rready = 1;
                    e_m_rvalid[o] = 1;
                    e_m_rresp[o*2 +: 2] = 2'b10;
                end else if (!md_addr_done) begin
                    e_s_arvalid = m_arvalid[o];
                    e_s_araddr = m_araddr[o*AW +: AW];
                    e_m_arready[o] = s_arready;
                end else begin
                    e_s_rready = m_rready[o];
                    e_m_rvalid[o] = s_rvalid;
                    e_m_rresp[o*2 +: 2] = s_rresp;
                    e_m_rdata[o*DW +: DW] = s_rdata;
                end
            end
            chk("s_arvalid", s_arvalid, e_s_arvalid);
            chk("s_araddr", s_araddr, e_s_araddr);
            chk("s_rready", s_rready, e_s_rready);
            chk("m_arready", m_arready, e_m_arready);
            chk("m_rvalid", m_rvalid, e_m_rvalid);
            chk("m_rresp", m_rresp, e_m_rresp);
            chk("m_rdata", m_rdata, e_m_rdata);

            if (s_arvalid && s_arready) begin
                gi = -1;
                for (int i = 0; i < NM; i++) if (m_arready[i]) gi = i;
                gnt_log.push_back(gi);
            end

            // Advance the model to the next cycle
            if (!rst) begin
                md_owner = -1; md_last = NM - 1; md_addr_done = 0; md_err = 0;
            end else if (o < 0) begin
                p = rr_pick(m_arvalid, md_last);
                if (p >= 0) begin
                    md_owner = p; md_addr_done = 0; md_err = 0; md_age = 0;
                end
            end else if (md_err) begin
                if (m_rready[o]) begin md_last = o; md_owner = -1; md_err = 0; end
            end else if (md_addr_done && s_rvalid && m_rready[o]) begin
                chk("rdata_e2e", m_rdata[o*DW +: DW], slv_data(md_addr));
                md_last = o; md_owner = -1;
            end else begin
                if (!md_addr_done && m_arvalid[o] && s_arready) begin
                    md_addr_done = 1;
                    md_addr = m_araddr[o*AW +: AW];
                end
`ifdef AXI_ARB_TIMEOUT_EN
                if (md_age == TB_TO - 1) md_err = 1;
`endif
                md_age++;
            end

            // Advance the slave
            if (!rst) begin
                sl_busy = 0;
            end else begin
                if (s_rvalid && s_rready) sl_busy = 0;
                if (s_arvalid && s_arready) begin
                    sl_busy = 1; sl_addr = s_araddr;
                    sl_delay = int'($urandom_range(0, max_delay));
                    sl_resp = resp_rand ? 2'($urandom_range(0, 3)) : 2'b00;
                end else if (sl_busy && sl_delay > 0) begin
                    sl_delay--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (sl_busy && sl_delay == 0 && !sl_silent) begin
            s_rvalid = 1; s_rdata = slv_data(sl_addr); s_rresp = sl_resp;
        end else begin
            s_rvalid = 0; s_rdata = {$urandom, $urandom}; s_rresp = 2'($urandom_range(0, 3));
        end
        s_arready = ($urandom_range(0, 99) < ar_pct);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 0; m_arvalid = '0; m_rready = '0;
        tick();
        rst = 1;
    endtask

    task automatic settle();
        int n = 0;
        m_rready = '1; ar_pct = 100; sl_silent = 0;
        while (md_owner >= 0 && n < 200) begin
            tick();
            m_arvalid = (!md_addr_done && !md_err) ? NM'(1 << md_owner) : '0;
            sample();
            n++;
        end
        chk("settle_bound", md_owner < 0, 1'b1);
        m_arvalid = '0;
    endtask

    task automatic single(input int r, input logic [31:0] a);
        tick();
        m_arvalid = NM'(1 << r);
        m_araddr[r*AW +: AW] = a;
        m_rready = '1;
        sample();
        settle();
    endtask

    initial begin
        int n;
        m_arvalid = '0; m_araddr = '0; m_rready = '0;
        s_arready = 0; s_rvalid = 0; s_rresp = '0; s_rdata = '0;
        ar_pct = 100; max_delay = 0; resp_rand = 0;
        do_reset();

        // Single request, zero-wait slave
        tick();
        m_arvalid = 4'b0001; m_araddr = {$urandom, $urandom, $urandom, 32'h8000_0000}; m_rready = '1;
        sample(); chk("t1_c0_arvalid", s_arvalid, 1'b0);
        tick();
        sample(); chk("t1_c1_arvalid", s_arvalid, 1'b1); chk("t1_c1_araddr", s_araddr, 32'h8000_0000);
        tick(); m_arvalid = '0;
        sample(); chk("t1_c2_rvalid", m_rvalid, 4'b0001);
        chk("t1_c2_rdata", m_rdata[63:0], 64'h1122_3344_5566_7788); chk("t1_c2_rresp", m_rresp, 8'h00);
        tick();
        sample(); chk("t1_c3_rvalid", m_rvalid, 4'b0000);

        // Fairness under full load
        max_delay = 2;
        do_reset();
        gnt_log.delete();
        tick(); m_arvalid = 4'b1111; m_rready = '1;
        n = 0;
        while (gnt_log.size() < 8 && n < 400) begin tick(); n++; end
        chk("fair_count", gnt_log.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("fair_order", gnt_log[i], i % 4);
        settle();

        // Skip idle requesters from last_grant=1
        do_reset();
        single(0, 32'h1000);
        single(1, 32'h2000);
        gnt_log.delete();
        tick(); m_arvalid = 4'b1001; m_rready = '1;
        n = 0;
        while (gnt_log.size() < 2 && n < 100) begin tick(); n++; end
        chk("skip_count", gnt_log.size() >= 2, 1'b1);
        if (gnt_log.size() >= 2) begin chk("skip_g0", gnt_log[0], 3); chk("skip_g1", gnt_log[1], 0); end
        settle();

        // Backpressure on both channels
        max_delay = 0;
        tick(); ar_pct = 0;
        m_arvalid = 4'b0100; m_araddr[2*AW +: AW] = 32'hCAFE_0040; m_rready = '0;
        sample();
        for (int k = 0; k < 5; k++) begin
            tick(); sample();
            chk("bp_arvalid", s_arvalid, 1'b1); chk("bp_araddr", s_araddr, 32'hCAFE_0040);
            chk("bp_arready", m_arready, 4'b0000);
        end
        ar_pct = 100;
        tick(); sample(); chk("bp_ar_hs", m_arready, 4'b0100);
        for (int k = 0; k < 3; k++) begin
            tick(); m_arvalid = '0; sample();
            chk("bp_rvalid_hold", m_rvalid, 4'b0100); chk("bp_rready_low", s_rready, 1'b0);
        end
        tick(); m_rready = '1; sample();
        chk("bp_rvalid", m_rvalid, 4'b0100);
        chk("bp_rdata", m_rdata[2*DW +: DW], 64'h5BDC_CDBA_5BDC_CDBA ^ 64'h9122_3344_D566_7788 ^ 64'hCAFE_0040_CAFE_0040 ^ 64'h5BDC_CDBA_5BDC_CDBA);
        chk("bp_rresp", m_rresp, 8'h00);
        tick(); sample(); chk("bp_done", m_rvalid, 4'b0000);

        // Reset while a read beat is pending in DATA
        do_reset();
        single(0, 32'h3000);
        tick(); m_arvalid = 4'b0010; m_rready = '0;
        tick();
        tick(); m_arvalid = '0;
        sample(); chk("rst_pending", m_rvalid, 4'b0010);
        tick(); rst = 0;
        tick(); rst = 1; m_arvalid = 4'b0101; m_rready = '1;
        sample();
        chk("rst_s_arvalid", s_arvalid, 1'b0); chk("rst_s_araddr", s_araddr, 32'h0);
        chk("rst_s_rready", s_rready, 1'b0); chk("rst_m_arready", m_arready, 4'b0);
        chk("rst_m_rvalid", m_rvalid, 4'b0); chk("rst_m_rresp", m_rresp, 8'h0);
        chk("rst_m_rdata", m_rdata, '0);
        tick(); sample(); chk("rst_regrant", m_arready, 4'b0001);
        settle();

`ifdef AXI_ARB_TIMEOUT_EN
        // Watchdog with a slave that never answers
        do_reset();
        sl_silent = 1;
        tick(); m_arvalid = 4'b0001; m_rready = '0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k >= 2) m_arvalid = '0;
            sample();
            if (k == 16) chk("to_before", m_rvalid, 4'b0000);
        end
        tick(); sample();
        chk("to_rvalid", m_rvalid, 4'b0001); chk("to_rresp", m_rresp[1:0], 2'b10);
        chk("to_rdata", m_rdata, '0); chk("to_s_rready", s_rready, 1'b1);
        tick(); sample(); chk("to_hold", m_rvalid, 4'b0001);
        tick(); m_rready = '1; sample();
        tick(); sample(); chk("to_exit", m_rvalid, 4'b0000);
        sl_silent = 0;
`endif

        // Randomized traffic with occasional resets
        do_reset();
        ar_pct = 60; max_delay = 3; resp_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 499) != 0);
            m_arvalid = NM'($urandom);
            m_araddr = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < NM; i++) m_rready[i] = ($urandom_range(0, 9) < 7);
        end
        rst = 1;
        settle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_rr_read_arbiter.md
AXI_RR_READ_ARBITER -- requirements
Module: axi_rr_read_arbiter

Interface
REQ-001 Parameter NUM_M, default 4, number of read requesters (2..8).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 64, data width.
REQ-004 Parameter TIMEOUT, default 255, watchdog limit in cycles; used only under REQ-027.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 m_arvalid  input  NUM_M  per-requester read-address valid.
REQ-008 m_araddr  input  NUM_M*AW  per-requester address, requester i at bits [i*AW +: AW].
REQ-009 m_arready  output  NUM_M  per-requester address ready.
REQ-010 m_rvalid  output  NUM_M  per-requester read-data valid.
REQ-011 m_rready  input  NUM_M  per-requester read-data ready.
REQ-012 m_rresp  output  NUM_M*2  per-requester response.
REQ-013 m_rdata  output  NUM_M*DW  per-requester read data.
REQ-014 s_arvalid, s_araddr[AW], s_rready  outputs; s_arready, s_rvalid, s_rresp[2], s_rdata[DW]  inputs: single shared slave read port.

Function
REQ-015 FSM states IDLE, ADDR, DATA, plus ERR when REQ-027 is enabled.
REQ-016 IDLE: when any m_arvalid is high, latch grant index g from the round-robin pick and go to ADDR next cycle. No request means stay in IDLE.
REQ-017 Round-robin pick: search starts at last_grant+1 and wraps modulo NUM_M. The first requester with m_arvalid high wins.
REQ-018 ADDR: s_arvalid=m_arvalid[g], s_araddr=m_araddr[g], m_arready[g]=s_arready. When s_arvalid&&s_arready, go to DATA.
REQ-019 DATA: s_rready=m_rready[g]. m_rvalid[g], m_rresp[g] and m_rdata[g] mirror the slave. When s_rvalid&&s_rready, go to IDLE and set last_grant=g.
REQ-020 Transfers are single-beat only. Exactly one outstanding transaction at any time.
REQ-021 All slave outputs are 0 outside ADDR/DATA, including s_araddr.
REQ-022 All outputs to non-granted requesters are 0, and all m_* outputs are 0 in IDLE.
REQ-023 Minimum latency: request in IDLE at cycle 0, s_arvalid at cycle 1, earliest m_rvalid at cycle 2 for a zero-wait slave.
REQ-024 A requester that drops m_arvalid in ADDR before the handshake keeps the grant. The FSM waits and does not re-arbitrate.
REQ-025 Back-to-back: a requester still asserting m_arvalid in the IDLE cycle after completion is arbitrated normally against the others.

Reset
REQ-026 On rst==0 at a clock edge:
- state=IDLE and last_grant=NUM_M-1, so requester 0 has first priority.
- Any in-flight transaction is abandoned.
- All outputs are 0 in the following cycle.

Configuration
REQ-027 Macro AXI_ARB_TIMEOUT_EN is a compile-time option.
- With the macro: a counter clears on entry to ADDR and increments each cycle in ADDR/DATA.
- When the counter reaches TIMEOUT without completion, go to ERR.
- ERR: s_arvalid=0 and s_rready=1, so late slave beats are discarded.
- ERR: m_rvalid[g]=1, m_rresp[g]=2'b10 (SLVERR), m_rdata[g]=0.
- ERR exits when m_rready[g] is high: go to IDLE and set last_grant=g.
- Without the macro: no counter, no ERR state, and the FSM may wait indefinitely.

Structure
REQ-028 Shared package axi_arb_pkg holds:
- the FSM state enum;
- RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
- the default TIMEOUT constant.
REQ-029 The round-robin pick is a combinational sub-module axi_rr_pick.
- Inputs: req[NUM_M], last[clog2].
- Outputs: gnt_idx and any_req.

Verification
REQ-030 Single request, zero-wait slave.
- Stimulus: m_arvalid=4'b0001, araddr0=0x8000_0000, slave returns 0x1122334455667788 immediately.
- Required: s_arvalid at cycle 1; m_rvalid[0] with that data at cycle 2, rresp=0.
REQ-031 Fairness under full load.
- Stimulus: all four requesters held high for 8 transactions after reset.
- Required grant order 0,1,2,3,0,1,2,3.
REQ-032 Skipping idle requesters.
- Stimulus: last_grant=1, m_arvalid=4'b1001.
- Required: grant 3, then grant 0.
REQ-033 Reset mid-operation.
- Stimulus: rst low during DATA with slave rvalid pending.
- Required: all outputs 0 next cycle; the next request from 0 or 2 grants 0.
REQ-034 Backpressure.
- Stimulus: slave s_arready low for 5 cycles, m_rready low for 3 cycles.
- Required: state and grant held; no data loss; completes with rresp=0.
REQ-035 Timeout (with AXI_ARB_TIMEOUT_EN, TIMEOUT=16).
- Stimulus: slave never asserts rvalid.
- Required: m_rvalid[g]=1 with rresp=2'b10 and rdata=0 at 16 cycles after entering ADDR; IDLE after m_rready.
